// File: rtl/apb_pkg.sv
// Shared APB constants and types for the two-port APB master/arbiter.
package apb_pkg;

    localparam logic [31:0] APB_START_ADDRESS   = 32'h8C00_0000;
    localparam logic [31:0] APB_END_ADDRESS     = 32'h8C00_0FFF;
    localparam int          APB_MAX_WAIT_STATES = 32;
    localparam int          APB_NUM_REQ         = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_master_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester handshake plus APB bus bundle; master = arbiter side, slave = environment side.
interface apb_master_arbiter_if;
    import apb_pkg::*;

    logic [APB_NUM_REQ-1:0]       req_valid;
    logic [APB_NUM_REQ-1:0]       req_write;
    logic [APB_NUM_REQ-1:0][31:0] req_addr;
    logic [APB_NUM_REQ-1:0][31:0] req_wdata;
    logic [APB_NUM_REQ-1:0]       req_ready;
    logic [APB_NUM_REQ-1:0]       resp_valid;
    logic [31:0]                  resp_rdata;
    logic                         resp_err;
    logic                         resp_timeout;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant; the last-grant pointer moves only when a transfer completes.
module apb_rr_arbiter
    import apb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [APB_NUM_REQ-1:0] req_valid,
    input  logic                   update,
    input  logic                   upd_idx,
    output logic                   gnt_valid,
    output logic                   gnt_idx
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_valid = |req_valid;
        gnt_idx   = 1'b0;
        unique case (req_valid)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_q;
            default: gnt_idx = 1'b0;
        endcase
        last_d = update ? upd_idx : last_q;
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB segment between two requesters: round-robin grant, decode check, wait-state abort.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_START = APB_START_ADDRESS,
    parameter logic [31:0] APB_END   = APB_END_ADDRESS,
    parameter int          MAX_WAIT  = APB_MAX_WAIT_STATES
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_master_arbiter_if.master bus
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    apb_master_state_t      state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [31:0]            paddr_q, paddr_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic [APB_NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;
    logic                   resp_timeout_q, resp_timeout_d;
    logic [APB_NUM_REQ-1:0] req_ready_c;
    logic                   arb_valid;
    logic                   arb_gnt;
    logic                   arb_update;

    assign arb_update = (state_q == RESP);

    apb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (bus.req_valid),
        .update    (arb_update),
        .upd_idx   (gnt_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_gnt)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d        = state_q;
        gnt_d          = gnt_q;
        wait_cnt_d     = wait_cnt_q;
        psel_d         = 1'b0;
        penable_d      = 1'b0;
        pwrite_d       = pwrite_q;
        paddr_d        = paddr_q;
        pwdata_d       = pwdata_q;
        resp_valid_d   = '0;
        resp_rdata_d   = '0;
        resp_err_d     = 1'b0;
        resp_timeout_d = 1'b0;
        req_ready_c    = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    req_ready_c[arb_gnt] = 1'b1;
                    gnt_d                = arb_gnt;
                    // Bus registers load only for decodable addresses, so PADDR keeps its last real value.
                    if (addr_in_range(bus.req_addr[arb_gnt], APB_START, APB_END)) begin
                        state_d    = SETUP;
                        psel_d     = 1'b1;
                        pwrite_d   = bus.req_write[arb_gnt];
                        paddr_d    = bus.req_addr[arb_gnt];
                        pwdata_d   = bus.req_wdata[arb_gnt];
                        wait_cnt_d = '0;
                    end else begin
                        state_d               = RESP;
                        resp_valid_d[arb_gnt] = 1'b1;
                        resp_err_d            = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d             = RESP;
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_err_d          = bus.PSLVERR;
                    if (!pwrite_q && !bus.PSLVERR) resp_rdata_d = bus.PRDATA;
                end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
                    state_d             = RESP;
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_err_d          = 1'b1;
                    resp_timeout_d      = 1'b1;
                end else begin
                    psel_d     = 1'b1;
                    penable_d  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_q          <= 1'b0;
            wait_cnt_q     <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            resp_valid_q   <= '0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            wait_cnt_q     <= wait_cnt_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    // Accept pulse is combinational so it lands in the IDLE cycle; masked while reset is held.
    assign bus.req_ready    = rst ? '0 : req_ready_c;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.PSEL         = psel_q;
    assign bus.PENABLE      = penable_q;
    assign bus.PWRITE       = pwrite_q;
    assign bus.PADDR        = paddr_q;
    assign bus.PWDATA       = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: one task per scenario, inline expected-value checks.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_arbiter_if bus ();

    apb_master_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          slv_wait     = 0;
    logic        slv_err      = 1'b0;
    logic [31:0] slv_rdata    = 32'hCAFE_F00D;

    // Slave model: raises PREADY after slv_wait ACCESS cycles.
    initial begin
        int acc_cnt;
        acc_cnt     = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        forever begin
            @(negedge clk);
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY  = (acc_cnt >= slv_wait);
                bus.PSLVERR = slv_err && bus.PREADY;
                acc_cnt++;
            end else begin
                acc_cnt     = 0;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end
            bus.PRDATA = slv_rdata;
        end
    end

    // Issues one request and reports what was observed; cycle numbers are relative to req_ready.
    task automatic do_xfer(input int r, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int budget,
                           output int rsp_cyc, output logic [31:0] rdata,
                           output logic err, output logic tmo,
                           output logic psel_seen, output logic psel_at_rsp,
                           output logic [31:0] paddr_s, output logic [31:0] pwdata_s,
                           output logic pwrite_s);
        int rdy;
        rdy = -1; rsp_cyc = -1; rdata = '0; err = 1'b0; tmo = 1'b0;
        psel_seen = 1'b0; psel_at_rsp = 1'b0; paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0;
        @(negedge clk);
        bus.req_valid[r] = 1'b1;
        bus.req_write[r] = wr;
        bus.req_addr[r]  = addr;
        bus.req_wdata[r] = wdata;
        #1;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (rdy >= 0) bus.req_valid[r] = 1'b0;
                #1;
            end
            if (rdy < 0 && bus.req_ready[r]) rdy = c;
            if (bus.PSEL) psel_seen = 1'b1;
            if (bus.PSEL && !bus.PENABLE) begin
                paddr_s  = bus.PADDR;
                pwdata_s = bus.PWDATA;
                pwrite_s = bus.PWRITE;
            end
            if (bus.resp_valid[r]) begin
                rsp_cyc     = c - rdy;
                rdata       = bus.resp_rdata;
                err         = bus.resp_err;
                tmo         = bus.resp_timeout;
                psel_at_rsp = bus.PSEL;
                break;
            end
        end
        bus.req_valid[r] = 1'b0;
    endtask

    int          rc;
    logic [31:0] rd, pa, pw;
    logic        er, tm, ps, pr, pwr;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.resp_timeout} !== '0) begin
            tests_failed++;
            $display("FAIL reset_resp: got ready=%b valid=%b rdata=%h err=%b tmo=%b, want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.resp_timeout);
        end
        tests_run++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== '0) begin
            tests_failed++;
            $display("FAIL reset_apb: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h, want all 0",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hCAFE_F00D;
        do_xfer(0, 1'b1, 32'h8C00_0004, 32'h0000_00A5, 20, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        tests_run++;
        if (rc !== 3) begin tests_failed++; $display("FAIL wr_latency: got %0d want 3", rc); end
        tests_run++;
        if (pa !== 32'h8C00_0004 || pw !== 32'h0000_00A5 || pwr !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_setup: got paddr=%h pwdata=%h pwrite=%b want 8c000004/000000a5/1", pa, pw, pwr);
        end
        tests_run++;
        if ({er, tm, rd} !== '0) begin
            tests_failed++;
            $display("FAIL wr_resp: got err=%b tmo=%b rdata=%h want 0/0/0", er, tm, rd);
        end
        @(negedge clk); #1;
        tests_run++;
        if (bus.PSEL !== 1'b0 || bus.PADDR !== 32'h8C00_0004) begin
            tests_failed++;
            $display("FAIL wr_idle_hold: got psel=%b paddr=%h want 0/8c000004", bus.PSEL, bus.PADDR);
        end
    endtask

    task automatic test_read_wait();
        slv_wait = 2; slv_rdata = 32'h1234_5678;
        do_xfer(1, 1'b0, 32'h8C00_0008, 32'h0, 20, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        tests_run++;
        if (rc !== 5) begin tests_failed++; $display("FAIL rd_latency: got %0d want 5", rc); end
        tests_run++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_data: got rdata=%h err=%b want 12345678/0", rd, er);
        end
        tests_run++;
        if (pa !== 32'h8C00_0008 || pwr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_setup: got paddr=%h pwrite=%b want 8c000008/0", pa, pwr);
        end
    endtask

    task automatic test_back_to_back();
        int g_idx[4], g_cyc[4], r_idx[4], r_cyc[4];
        int ngr, nrsp;
        logic dropped, dual;
        ngr = 0; nrsp = 0; dropped = 1'b0; dual = 1'b0;
        slv_wait = 0; slv_rdata = 32'h0;
        @(negedge clk);
        bus.req_write = 2'b11;
        bus.req_addr[0] = 32'h8C00_0010; bus.req_wdata[0] = 32'h1111_0000;
        bus.req_addr[1] = 32'h8C00_0020; bus.req_wdata[1] = 32'h2222_0000;
        bus.req_valid = 2'b11;
        #1;
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (ngr == 4 && !dropped) begin bus.req_valid = 2'b00; dropped = 1'b1; end
                #1;
            end
            if (bus.req_ready == 2'b11) dual = 1'b1;
            if (bus.req_ready != 2'b00 && ngr < 4) begin
                g_idx[ngr] = int'(bus.req_ready[1]); g_cyc[ngr] = c; ngr++;
            end
            if (bus.resp_valid != 2'b00 && nrsp < 4) begin
                r_idx[nrsp] = int'(bus.resp_valid[1]); r_cyc[nrsp] = c; nrsp++;
            end
        end
        bus.req_valid = 2'b00;
        tests_run++;
        if (ngr !== 4 || nrsp !== 4 || dual !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_count: got grants=%0d resps=%0d dual=%b want 4/4/0", ngr, nrsp, dual);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (g_idx[i] !== (i % 2) || r_idx[i] !== (i % 2)) begin
                    tests_failed++;
                    $display("FAIL b2b_order[%0d]: got grant=%0d resp=%0d want %0d", i, g_idx[i], r_idx[i], i % 2);
                end
                tests_run++;
                if (r_cyc[i] - g_cyc[i] !== 3 || g_cyc[i] !== 4 * i) begin
                    tests_failed++;
                    $display("FAIL b2b_timing[%0d]: got grant@%0d resp@%0d want grant@%0d resp@%0d",
                             i, g_cyc[i], r_cyc[i], 4 * i, 4 * i + 3);
                end
            end
        end
    endtask

    task automatic test_decode_error();
        do_xfer(0, 1'b0, 32'h9000_0000, 32'h0, 20, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        tests_run++;
        if (rc !== 1 || er !== 1'b1 || tm !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode_err: got cyc=%0d err=%b tmo=%b want 1/1/0", rc, er, tm);
        end
        tests_run++;
        if (ps !== 1'b0) begin tests_failed++; $display("FAIL decode_psel: got psel_seen=%b want 0", ps); end
    endtask

    task automatic test_timeout();
        slv_wait = 1000; slv_rdata = 32'hDEAD_BEEF;
        do_xfer(1, 1'b0, 32'h8C00_000C, 32'h0, 60, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        tests_run++;
        if (rc !== 35) begin tests_failed++; $display("FAIL tmo_latency: got %0d want 35", rc); end
        tests_run++;
        if (er !== 1'b1 || tm !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL tmo_flags: got err=%b tmo=%b rdata=%h want 1/1/0", er, tm, rd);
        end
        tests_run++;
        if (ps !== 1'b1 || pr !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_psel: got seen=%b at_resp=%b want 1/0", ps, pr);
        end
    endtask

    task automatic test_slverr();
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h5555_AAAA;
        do_xfer(0, 1'b0, 32'h8C00_0030, 32'h0, 20, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        slv_err = 1'b0;
        tests_run++;
        if (rc !== 3 || er !== 1'b1 || tm !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL slverr: got cyc=%0d err=%b tmo=%b rdata=%h want 3/1/0/0", rc, er, tm, rd);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic in_access, rdy_seen, stray;
        in_access = 1'b0; rdy_seen = 1'b0; stray = 1'b0;
        slv_wait = 1000;
        @(negedge clk);
        bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b1;
        bus.req_addr[0] = 32'h8C00_0040; bus.req_wdata[0] = 32'h0000_0077;
        #1;
        for (int c = 0; c < 20 && !in_access; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (rdy_seen) bus.req_valid[0] = 1'b0;
                #1;
            end
            if (bus.req_ready[0]) rdy_seen = 1'b1;
            if (bus.PSEL && bus.PENABLE) in_access = 1'b1;
        end
        bus.req_valid[0] = 1'b0;
        tests_run++;
        if (in_access !== 1'b1) begin tests_failed++; $display("FAIL rstmid_access: got %b want 1", in_access); end
        rst = 1'b1;
        @(negedge clk); #1;
        tests_run++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_timeout, bus.resp_rdata,
             bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got psel=%b pen=%b paddr=%h valid=%b want all 0",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.resp_valid);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (bus.resp_valid != 2'b00) stray = 1'b1;
        end
        tests_run++;
        if (stray !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_resp: got stray=%b want 0", stray); end
        slv_wait = 0;
        do_xfer(0, 1'b1, 32'h8C00_0044, 32'h0000_0099, 20, rc, rd, er, tm, ps, pr, pa, pw, pwr);
        tests_run++;
        if (rc !== 3 || er !== 1'b0 || pa !== 32'h8C00_0044 || pw !== 32'h0000_0099) begin
            tests_failed++;
            $display("FAIL rstmid_recover: got cyc=%0d err=%b paddr=%h pwdata=%h want 3/0/8c000044/00000099",
                     rc, er, pa, pw);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_decode_error();
        test_timeout();
        test_slverr();
        test_reset_mid_transfer();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
